// File: rtl/isr_output_checker_if.sv
// isr_output_checker_if
// Bundles the run-control, expected-word and result-word signals of the
// inverse-square-root output checker.
//   master : test environment side (drives Start/SampleCount/ExpData/ExpValid/
//            DataIn/DataValid, observes status)
//   slave  : checker side
// Handshake: an expected word transfers on a rising edge where ce, ExpValid
// and ExpReady are all high. A result word has no backpressure; it is taken
// on any rising edge where ce and DataValid are high and a run is active.
interface isr_output_checker_if #(
  parameter int CNT_W = 16
);
  logic             Start;
  logic [CNT_W-1:0] SampleCount;
  logic [31:0]      ExpData;
  logic             ExpValid;
  logic             ExpReady;
  logic [31:0]      DataIn;
  logic             DataValid;
  logic             Busy;
  logic             Done;
  logic             Pass;
  logic [CNT_W-1:0] ErrCount;
  logic [CNT_W-1:0] ErrIndex;
  logic             Underflow;

  modport master (
    output Start, SampleCount, ExpData, ExpValid, DataIn, DataValid,
    input  ExpReady, Busy, Done, Pass, ErrCount, ErrIndex, Underflow
  );

  modport slave (
    input  Start, SampleCount, ExpData, ExpValid, DataIn, DataValid,
    output ExpReady, Busy, Done, Pass, ErrCount, ErrIndex, Underflow
  );
endinterface

// File: rtl/isr_output_checker.sv
// isr_output_checker
// Compares the result stream of an inverse-square-root unit against a FIFO of
// golden words. A run checks SampleCount results; each result pops one golden
// word and is a mismatch when the absolute raw difference exceeds TOL.
// Ports:
//   clk       : clock, rising edge
//   rst       : synchronous active-high reset (overrides ce and Start)
//   ce        : clock enable, all state holds when low
//   bus       : slave modport of isr_output_checker_if
//   dbg_state : current FSM state (0 idle, 1 run, 2 done)
//   dbg_level : current golden-FIFO occupancy
module isr_output_checker #(
  parameter int DEPTH = 16,
  parameter int TOL   = 2,
  parameter int CNT_W = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     ce,
  isr_output_checker_if.slave      bus,
  output logic [1:0]               dbg_state,
  output logic [$clog2(DEPTH):0]   dbg_level
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0]      PTR_ONE = 1;
  localparam logic [CNT_W-1:0] CNT_ONE = 1;
  localparam logic [31:0]      TOL_W   = 32'(TOL);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           state;
  logic [CNT_W-1:0] target;
  logic [CNT_W-1:0] compared;
  logic [CNT_W-1:0] err_count;
  logic [CNT_W-1:0] err_index;
  logic             underflow;
  logic             done;
  logic             pass;

  logic [31:0] mem [DEPTH];
  logic [AW:0] wr_ptr;
  logic [AW:0] rd_ptr;

  // Registered comparison stage: one entry per accepted result.
  logic stg_valid;
  logic stg_mis;
  logic stg_under;

  logic        empty, full, exp_ready, push, accept, pop;
  logic [31:0] head, diff;
  logic        mis;
  logic        upd, bad, last;
  logic [CNT_W-1:0] compared_nx, err_count_nx, err_index_nx;
  logic        underflow_nx;

  always_comb begin
    empty     = (wr_ptr == rd_ptr);
    full      = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    exp_ready = (state == S_RUN) && !full;
    push      = bus.ExpValid && exp_ready;
    accept    = bus.DataValid && (state == S_RUN);
    // No bypass: a result arriving on an empty FIFO is an underflow even if a
    // golden word is being pushed in the same cycle.
    pop       = accept && !empty;
    head      = mem[rd_ptr[AW-1:0]];
    diff      = (bus.DataIn >= head) ? (bus.DataIn - head) : (head - bus.DataIn);
    mis       = diff > TOL_W;

    upd          = stg_valid && (state == S_RUN);
    bad          = stg_mis || stg_under;
    compared_nx  = compared + CNT_ONE;
    err_count_nx = (bad && (err_count != '1)) ? err_count + CNT_ONE : err_count;
    // ErrCount never returns to zero within a run, so zero marks "no mismatch yet".
    err_index_nx = (bad && (err_count == '0)) ? compared : err_index;
    underflow_nx = underflow | stg_under;
    last         = (compared_nx == target);
  end

  always_ff @(posedge clk) begin
    if (!rst && ce && push) begin
      mem[wr_ptr[AW-1:0]] <= bus.ExpData;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      target    <= '0;
      compared  <= '0;
      err_count <= '0;
      err_index <= '0;
      underflow <= 1'b0;
      done      <= 1'b0;
      pass      <= 1'b0;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      stg_valid <= 1'b0;
      stg_mis   <= 1'b0;
      stg_under <= 1'b0;
    end else if (ce) begin
      stg_valid <= accept;
      stg_mis   <= mis && !empty;
      stg_under <= empty;
      if (push) wr_ptr <= wr_ptr + PTR_ONE;
      if (pop)  rd_ptr <= rd_ptr + PTR_ONE;

      case (state)
        S_IDLE, S_DONE: begin
          if (bus.Start) begin
            target    <= bus.SampleCount;
            compared  <= '0;
            err_count <= '0;
            err_index <= '0;
            underflow <= 1'b0;
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            stg_valid <= 1'b0;
            if (bus.SampleCount == '0) begin
              state <= S_DONE;
              done  <= 1'b1;
              pass  <= 1'b1;
            end else begin
              state <= S_RUN;
              done  <= 1'b0;
              pass  <= 1'b0;
            end
          end
        end
        S_RUN: begin
          if (upd) begin
            compared  <= compared_nx;
            err_count <= err_count_nx;
            err_index <= err_index_nx;
            underflow <= underflow_nx;
            if (last) begin
              state <= S_DONE;
              done  <= 1'b1;
              pass  <= (err_count_nx == '0) && !underflow_nx;
            end
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign bus.ExpReady  = exp_ready;
  assign bus.Busy      = (state == S_RUN);
  assign bus.Done      = done;
  assign bus.Pass      = pass;
  assign bus.ErrCount  = err_count;
  assign bus.ErrIndex  = err_index;
  assign bus.Underflow = underflow;
  assign dbg_state     = state;
  assign dbg_level     = wr_ptr - rd_ptr;
endmodule

// File: tb/tb_isr_output_checker.sv
module tb_isr_output_checker;
  localparam int DEPTH = 16;
  localparam int TOL   = 2;
  localparam int CNT_W = 16;

  logic                   clk = 1'b0;
  logic                   rst;
  logic                   ce;
  logic [1:0]             dbg_state;
  logic [$clog2(DEPTH):0] dbg_level;

  int n_vec = 0;
  int n_bad = 0;

  isr_output_checker_if #(.CNT_W(CNT_W)) bus ();

  isr_output_checker #(.DEPTH(DEPTH), .TOL(TOL), .CNT_W(CNT_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .ce        (ce),
    .bus       (bus),
    .dbg_state (dbg_state),
    .dbg_level (dbg_level)
  );

  // clock / reset
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  // driver tasks: inputs change and outputs are sampled on the falling edge
  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    bus.Start       = 1'b0;
    bus.SampleCount = '0;
    bus.ExpData     = '0;
    bus.ExpValid    = 1'b0;
    bus.DataIn      = '0;
    bus.DataValid   = 1'b0;
  endtask

  task automatic start_run(input logic [CNT_W-1:0] count);
    bus.Start       = 1'b1;
    bus.SampleCount = count;
    step();
    bus.Start       = 1'b0;
  endtask

  task automatic push(input logic [31:0] val);
    bus.ExpValid = 1'b1;
    bus.ExpData  = val;
    step();
    bus.ExpValid = 1'b0;
  endtask

  task automatic result(input logic [31:0] val);
    bus.DataValid = 1'b1;
    bus.DataIn    = val;
    step();
    bus.DataValid = 1'b0;
  endtask

  initial begin
    idle_inputs();
    rst = 1'b1;
    ce  = 1'b1;
    step();
    step();
    rst = 1'b0;

    // reset state, and expected/result words ignored in idle
    check("rst_state",     32'(dbg_state), 32'd0);
    check("rst_busy",      32'(bus.Busy), 32'd0);
    check("rst_done",      32'(bus.Done), 32'd0);
    check("rst_pass",      32'(bus.Pass), 32'd0);
    check("rst_errcount",  32'(bus.ErrCount), 32'd0);
    check("rst_errindex",  32'(bus.ErrIndex), 32'd0);
    check("rst_underflow", 32'(bus.Underflow), 32'd0);
    check("rst_expready",  32'(bus.ExpReady), 32'd0);
    bus.ExpValid = 1'b1;
    bus.DataValid = 1'b1;
    step();
    idle_inputs();
    check("idle_level",    32'(dbg_level), 32'd0);
    check("idle_errcount", 32'(bus.ErrCount), 32'd0);

    // four exact matches
    start_run(16'd4);
    check("run_busy",     32'(bus.Busy), 32'd1);
    check("run_state",    32'(dbg_state), 32'd1);
    check("run_expready", 32'(bus.ExpReady), 32'd1);
    for (int i = 0; i < 4; i++) push(32'h5F3759DF + 32'(i));
    check("match_level", 32'(dbg_level), 32'd4);
    for (int i = 0; i < 4; i++) result(32'h5F3759DF + 32'(i));
    check("match_done_early", 32'(bus.Done), 32'd0);
    step();
    check("match_done",     32'(bus.Done), 32'd1);
    check("match_pass",     32'(bus.Pass), 32'd1);
    check("match_errcount", 32'(bus.ErrCount), 32'd0);
    check("match_busy",     32'(bus.Busy), 32'd0);
    check("match_state",    32'(dbg_state), 32'd2);

    // tolerance boundary: diff 2 passes, diff 3 fails at index 1
    start_run(16'd2);
    push(32'h3F800000);
    push(32'h3F800000);
    result(32'h3F800002);
    result(32'h3F800003);
    step();
    check("tol_done",     32'(bus.Done), 32'd1);
    check("tol_errcount", 32'(bus.ErrCount), 32'd1);
    check("tol_errindex", 32'(bus.ErrIndex), 32'd1);
    check("tol_pass",     32'(bus.Pass), 32'd0);

    // result below golden, and first-mismatch index held across later mismatches
    start_run(16'd3);
    for (int i = 0; i < 3; i++) push(32'h00000010);
    result(32'h0000000E);
    result(32'h0000000D);
    result(32'h00000020);
    step();
    check("abs_done",     32'(bus.Done), 32'd1);
    check("abs_errcount", 32'(bus.ErrCount), 32'd2);
    check("abs_errindex", 32'(bus.ErrIndex), 32'd1);
    check("abs_pass",     32'(bus.Pass), 32'd0);

    // underflow, including push and result in the same cycle on an empty FIFO
    start_run(16'd2);
    bus.ExpValid = 1'b1; bus.ExpData = 32'h5;
    bus.DataValid = 1'b1; bus.DataIn = 32'h5;
    step();
    bus.ExpValid = 1'b0;
    check("uf_lag",   32'(bus.Underflow), 32'd0);
    check("uf_level", 32'(dbg_level), 32'd1);
    result(32'h5);
    check("uf_sticky", 32'(bus.Underflow), 32'd1);
    step();
    check("uf_done",     32'(bus.Done), 32'd1);
    check("uf_flag",     32'(bus.Underflow), 32'd1);
    check("uf_errcount", 32'(bus.ErrCount), 32'd1);
    check("uf_errindex", 32'(bus.ErrIndex), 32'd0);
    check("uf_pass",     32'(bus.Pass), 32'd0);
    check("uf_level_end", 32'(dbg_level), 32'd0);

    // fill to full, pop while full, then push and pop together
    start_run(16'd2);
    for (int i = 0; i < 15; i++) push(32'(i));
    check("fill15_ready", 32'(bus.ExpReady), 32'd1);
    push(32'd15);
    check("full_ready", 32'(bus.ExpReady), 32'd0);
    check("full_level", 32'(dbg_level), 32'd16);
    bus.ExpValid = 1'b1; bus.ExpData = 32'd99;
    result(32'd0);
    bus.ExpValid = 1'b0;
    check("pop_full_level", 32'(dbg_level), 32'd15);
    check("pop_full_ready", 32'(bus.ExpReady), 32'd1);
    bus.ExpValid = 1'b1; bus.ExpData = 32'd77;
    result(32'd1);
    bus.ExpValid = 1'b0;
    check("pushpop_level", 32'(dbg_level), 32'd15);
    step();
    check("full_done",     32'(bus.Done), 32'd1);
    check("full_pass",     32'(bus.Pass), 32'd1);
    check("done_expready", 32'(bus.ExpReady), 32'd0);

    // clock enable low holds everything; then reset mid-run
    start_run(16'd3);
    check("restart_level", 32'(dbg_level), 32'd0);
    push(32'd7);
    push(32'd8);
    push(32'd9);
    result(32'd7);
    ce = 1'b0;
    bus.DataValid = 1'b1; bus.DataIn = 32'd0;
    bus.ExpValid = 1'b1; bus.ExpData = 32'd55;
    for (int i = 0; i < 3; i++) step();
    check("ce_errcount", 32'(bus.ErrCount), 32'd0);
    check("ce_level",    32'(dbg_level), 32'd2);
    check("ce_busy",     32'(bus.Busy), 32'd1);
    ce = 1'b1;
    idle_inputs();
    step();
    result(32'd0);
    step();
    check("ce_after_errcount", 32'(bus.ErrCount), 32'd1);
    check("ce_after_errindex", 32'(bus.ErrIndex), 32'd1);
    check("ce_after_busy",     32'(bus.Busy), 32'd1);
    rst = 1'b1; ce = 1'b0; bus.Start = 1'b1; bus.SampleCount = 16'd0;
    step();
    rst = 1'b0; ce = 1'b1;
    idle_inputs();
    check("abort_state",     32'(dbg_state), 32'd0);
    check("abort_busy",      32'(bus.Busy), 32'd0);
    check("abort_done",      32'(bus.Done), 32'd0);
    check("abort_pass",      32'(bus.Pass), 32'd0);
    check("abort_errcount",  32'(bus.ErrCount), 32'd0);
    check("abort_errindex",  32'(bus.ErrIndex), 32'd0);
    check("abort_underflow", 32'(bus.Underflow), 32'd0);
    check("abort_expready",  32'(bus.ExpReady), 32'd0);
    check("abort_level",     32'(dbg_level), 32'd0);
    step();
    check("abort_no_done", 32'(bus.Done), 32'd0);

    // zero-length run, results ignored in done, restart, start ignored in run
    start_run(16'd0);
    check("zero_done",  32'(bus.Done), 32'd1);
    check("zero_pass",  32'(bus.Pass), 32'd1);
    check("zero_busy",  32'(bus.Busy), 32'd0);
    result(32'd123);
    check("zero_ign_errcount",  32'(bus.ErrCount), 32'd0);
    check("zero_ign_underflow", 32'(bus.Underflow), 32'd0);
    start_run(16'd1);
    check("again_busy", 32'(bus.Busy), 32'd1);
    check("again_done", 32'(bus.Done), 32'd0);
    check("again_pass", 32'(bus.Pass), 32'd0);
    start_run(16'd0);
    check("start_in_run_busy", 32'(bus.Busy), 32'd1);
    push(32'h12345678);
    result(32'h12345679);
    step();
    check("again_final_done", 32'(bus.Done), 32'd1);
    check("again_final_pass", 32'(bus.Pass), 32'd1);

    // final report
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
